button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 143 ++++++++++++++
 tb/tb_button_debounce.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button debouncer: optional input inversion, 2-flop synchronizer,
// four-state arm/accept FSM with a stability counter, and registered
// level / edge-strobe / toggle / press-counter outputs.
module button_debounce #(
    parameter int STABLE_CYCLES = 120000,
    parameter int CNT_W         = 17,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       led_toggle,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    // Terminal count: the input has been stable for STABLE_CYCLES samples.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             btn_raw;
    logic             sync1_q;
    logic             sync2_q;
    logic             btn_s;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_evt;
    logic             release_evt;

    logic             btn_level_q;
    logic             press_pulse_q;
    logic             release_pulse_q;
    logic             led_toggle_q;
    logic [7:0]       press_count_q;

    // Normalise polarity so that 1 always means "pressed" downstream.
    assign btn_raw = ACTIVE_LOW ? ~button : button;
    assign btn_s   = sync2_q;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter only runs in the two arming states,
    // so it can never pass CNT_LAST and is parked at zero otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d = ARM_PRESS;
                end
            end
            ARM_PRESS: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = PRESSED;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = ARM_RELEASE;
                end
            end
            ARM_RELEASE: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RELEASED;
                    release_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    // Registered outputs, derived from the transition being taken this
    // cycle so they line up with the new FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            led_toggle_q    <= 1'b0;
            press_count_q   <= 8'd0;
        end else begin
            btn_level_q     <= (state_d == PRESSED) || (state_d == ARM_RELEASE);
            press_pulse_q   <= press_evt;
            release_pulse_q <= release_evt;
            if (press_evt) begin
                led_toggle_q  <= ~led_toggle_q;
                press_count_q <= press_count_q + 8'd1;
            end
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign led_toggle    = led_toggle_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (STABLE_CYCLES=4): expectations are
// queued with the cycle they are due and checked on the falling edge.
module tb_button_debounce;

    logic       clk;
    logic       rst_n;
    logic       b0;
    logic       b1;
    logic       lvl0, pp0, rp0, tog0;
    logic       lvl1, pp1, rp1, tog1;
    logic [7:0] cnt0, cnt1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_pp0       = 0;
    int n_rp0       = 0;
    logic pp0_prev  = 1'b0;
    logic pp1_prev  = 1'b0;

    typedef struct {
        int          cyc;
        int          dut;
        string       tag;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [11:0] obs;

    button_debounce #(.STABLE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .button(b0),
        .btn_level(lvl0), .press_pulse(pp0), .release_pulse(rp0),
        .led_toggle(tog0), .press_count(cnt0)
    );

    button_debounce #(.STABLE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .button(b1),
        .btn_level(lvl1), .press_pulse(pp1), .release_pulse(rp1),
        .led_toggle(tog1), .press_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue an expectation due 'off' rising edges from now.
    task automatic expect_at(input int off, input int dut, input string tag,
                             input logic lvl, input logic pp, input logic rp,
                             input logic tog, input logic [7:0] cnt);
        exp_t x;
        x.cyc = cyc + off;
        x.dut = dut;
        x.tag = tag;
        x.exp = {lvl, pp, rp, tog, cnt};
        sb.push_back(x);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard drain and per-cycle pulse invariants.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            obs = (e.dut == 0) ? {lvl0, pp0, rp0, tog0, cnt0}
                               : {lvl1, pp1, rp1, tog1, cnt1};
            vectors++;
            assert (obs === e.exp && e.cyc == cyc) else begin
                miscompares++;
                $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h",
                       e.tag, e.dut, cyc, obs, e.exp);
            end
        end
        vectors++;
        assert (((pp0 & rp0) !== 1'b1) && ((pp1 & rp1) !== 1'b1)) else begin
            miscompares++;
            $error("FAIL pulse_overlap cyc=%0d observed=%b%b/%b%b expected=no overlap",
                   cyc, pp0, rp0, pp1, rp1);
        end
        vectors++;
        assert (!(pp0 === 1'b1 && pp0_prev === 1'b1) &&
                !(pp1 === 1'b1 && pp1_prev === 1'b1)) else begin
            miscompares++;
            $error("FAIL press_pulse_width cyc=%0d observed=2 cycles expected=1", cyc);
        end
        pp0_prev = pp0;
        pp1_prev = pp1;
        if (pp0 === 1'b1) n_pp0++;
        if (rp0 === 1'b1) n_rp0++;
    end

    initial begin
        int pp_base;
        int rp_base;
        rst_n = 1'b0;
        b0    = 1'b0;
        b1    = 1'b1;

        // Reset state.
        @(negedge clk);
        for (int k = 1; k <= 2; k++) begin
            expect_at(k, 0, "reset", 0, 0, 0, 0, 8'd0);
            expect_at(k, 1, "reset", 0, 0, 0, 0, 8'd0);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) expect_at(k, 0, "idle", 0, 0, 0, 0, 8'd0);
        wait_cycles(4);

        // Clean press: accepted after edge 7 only.
        b0 = 1'b1;
        expect_at(6, 0, "press_early", 0, 0, 0, 0, 8'd0);
        expect_at(7, 0, "press_edge7", 1, 1, 0, 1, 8'd1);
        expect_at(8, 0, "press_after", 1, 0, 0, 1, 8'd1);
        wait_cycles(20);

        // Clean release: count unchanged.
        b0 = 1'b0;
        expect_at(6, 0, "rel_early", 1, 0, 0, 1, 8'd1);
        expect_at(7, 0, "rel_edge7", 0, 0, 1, 1, 8'd1);
        expect_at(8, 0, "rel_after", 0, 0, 0, 1, 8'd1);
        wait_cycles(20);

        // Bounce: 3 high, 2 low, then held; accepted 7 edges after final rise.
        for (int k = 1; k <= 11; k++) expect_at(k, 0, "bounce_quiet", 0, 0, 0, 1, 8'd1);
        expect_at(12, 0, "bounce_accept", 1, 1, 0, 0, 8'd2);
        expect_at(13, 0, "bounce_after", 1, 0, 0, 0, 8'd2);
        b0 = 1'b1;
        wait_cycles(3);
        b0 = 1'b0;
        wait_cycles(2);
        b0 = 1'b1;
        wait_cycles(20);

        b0 = 1'b0;
        expect_at(7, 0, "rel2_edge7", 0, 0, 1, 0, 8'd2);
        expect_at(8, 0, "rel2_after", 0, 0, 0, 0, 8'd2);
        wait_cycles(20);

        // 256 press/release cycles: count wraps back, toggle returns.
        pp_base = n_pp0;
        rp_base = n_rp0;
        for (int i = 0; i < 256; i++) begin
            b0 = 1'b1;
            expect_at(7, 0, "wrap_press", 1, 1, 0, logic'((3 + i) % 2), 8'((3 + i) % 256));
            wait_cycles(10);
            b0 = 1'b0;
            expect_at(7, 0, "wrap_rel", 0, 0, 1, logic'((3 + i) % 2), 8'((3 + i) % 256));
            wait_cycles(10);
        end
        vectors++;
        assert ((n_pp0 - pp_base) == 256 && (n_rp0 - rp_base) == 256) else begin
            miscompares++;
            $error("FAIL wrap_pulses observed=%0d/%0d expected=256/256",
                   n_pp0 - pp_base, n_rp0 - rp_base);
        end

        // Reset at edge 5 of a press; re-acceptance 7 edges after release.
        b0 = 1'b1;
        for (int k = 1; k <= 4; k++) expect_at(k, 0, "rst_arming", 0, 0, 0, 0, 8'd2);
        expect_at(5, 0, "rst_clear", 0, 0, 0, 0, 8'd0);
        expect_at(5, 1, "rst_clear", 0, 0, 0, 0, 8'd0);
        for (int k = 6; k <= 11; k++) expect_at(k, 0, "rst_rearm", 0, 0, 0, 0, 8'd0);
        expect_at(12, 0, "rst_accept", 1, 1, 0, 1, 8'd1);
        expect_at(13, 0, "rst_after", 1, 0, 0, 1, 8'd1);
        wait_cycles(4);
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(10);
        b0 = 1'b0;
        expect_at(7, 0, "rst_rel", 0, 0, 1, 1, 8'd1);
        wait_cycles(12);

        // Active-low instance: input 1->0 is a press.
        b1 = 1'b0;
        expect_at(6, 1, "al_early", 0, 0, 0, 0, 8'd0);
        expect_at(7, 1, "al_press", 1, 1, 0, 1, 8'd1);
        expect_at(8, 1, "al_after", 1, 0, 0, 1, 8'd1);
        wait_cycles(12);
        b1 = 1'b1;
        expect_at(7, 1, "al_rel", 0, 0, 1, 1, 8'd1);
        wait_cycles(12);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
